// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: core request/response
// structs, FSM state encoding and byte-lane helpers.
package dmem_responder_pkg;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic        valid;
        logic        yumi;
        logic [31:0] read_data;
    } mem_out_s;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_e;

    localparam int cnt_width_lp = 4;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        return {24'b0, shifted[7:0]};
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous 32-bit word array with per-byte write enables.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [3:0]              we,
    input  logic [addr_width_p-1:0] addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata
);

    logic [31:0] mem [0:(1<<addr_width_p)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with valid/yumi handshake.
// Optional out-of-range detection is enabled with DMEM_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for a core request; yumi follows from_core_i.valid
// BUSY  | latency countdown, request latched
// RESP  | response valid and held until the core yumis it
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     from_core_i,
    input  logic [31:0] addr_i,
    output mem_out_s    to_core_o,
    output logic        error_o
);

    localparam int aw_lp = addr_width_p + 2;

    dmem_state_e             state;
    logic [cnt_width_lp-1:0] count;
    logic [aw_lp-1:0]        addr_q;
    logic [31:0]             wdata_q;
    logic                    wen_q;
    logic                    bnw_q;
    logic                    oor_q;
    logic                    valid_q;
    logic                    err_q;

    logic accept;
    logic oor_in;
    assign accept = reset && (state == IDLE) && from_core_i.valid;

`ifdef DMEM_RANGE_CHECK_EN
    assign oor_in  = (addr_i >> aw_lp) != 32'd0;
    assign error_o = err_q;
`else
    assign oor_in  = 1'b0;
    assign error_o = 1'b0;
    logic unused_nochk;
    assign unused_nochk = ^{addr_i[31:aw_lp], err_q};
`endif

    // With a one-cycle latency the array is hit on the acceptance edge itself,
    // so the access fields come straight from the inputs rather than the latches.
    logic             direct;
    logic             enter_resp;
    logic [aw_lp-1:0] acc_addr;
    logic [31:0]      acc_wdata;
    logic             acc_wen;
    logic             acc_bnw;
    logic             acc_oor;

    assign direct     = (latency_p == 1) && accept;
    assign enter_resp = direct || ((state == BUSY) && (count <= 4'd1));
    assign acc_addr   = direct ? addr_i[aw_lp-1:0]       : addr_q;
    assign acc_wdata  = direct ? from_core_i.write_data  : wdata_q;
    assign acc_wen    = direct ? from_core_i.wen         : wen_q;
    assign acc_bnw    = direct ? from_core_i.byte_not_word : bnw_q;
    assign acc_oor    = direct ? oor_in                  : oor_q;

    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always_comb begin
        mem_we    = 4'h0;
        mem_wdata = acc_bnw ? {4{acc_wdata[7:0]}} : acc_wdata;
        if (acc_wen && !acc_oor) mem_we = acc_bnw ? lane_mask(acc_addr[1:0]) : 4'hF;
    end

    dmem_array #(
        .addr_width_p(addr_width_p)
    ) u_array (
        .clk  (clk),
        .en   (enter_resp),
        .we   (mem_we),
        .addr (acc_addr[aw_lp-1:2]),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            bnw_q   <= 1'b0;
            oor_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= addr_i[aw_lp-1:0];
                        wdata_q <= from_core_i.write_data;
                        wen_q   <= from_core_i.wen;
                        bnw_q   <= from_core_i.byte_not_word;
                        oor_q   <= oor_in;
                        count   <= cnt_width_lp'(latency_p - 1);
                        if (latency_p == 1) begin
                            state   <= RESP;
                            valid_q <= 1'b1;
                            err_q   <= oor_in;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (count <= 4'd1) begin
                        state   <= RESP;
                        valid_q <= 1'b1;
                        err_q   <= oor_q;
                    end
                end
                RESP: begin
                    if (from_core_i.yumi) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        to_core_o.valid     = valid_q;
        to_core_o.yumi      = accept;
        to_core_o.read_data = 32'd0;
        if (valid_q && !wen_q && !oor_q)
            to_core_o.read_data = bnw_q ? lane_extract(mem_rdata, addr_q[1:0]) : mem_rdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (addr_width_p=10, latency_p=2).
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    mem_in_s     core_in;
    logic [31:0] addr_in;
    mem_out_s    to_core;
    logic        error_o;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_responder #(
        .addr_width_p(10),
        .latency_p   (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .from_core_i(core_in),
        .addr_i     (addr_in),
        .to_core_o  (to_core),
        .error_o    (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input string tag, input logic wen, input logic bnw,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int n;
        core_in.valid         = 1'b1;
        core_in.wen           = wen;
        core_in.byte_not_word = bnw;
        core_in.write_data    = wdata;
        core_in.yumi          = (hold == 0);
        addr_in               = addr;
        #1;
        chk({tag, "_yumi_o"}, 32'(to_core.yumi), 32'd1);
        tick();
        core_in.valid      = 1'b0;
        core_in.write_data = '0;
        addr_in            = '0;
        n = 1;
        while (!to_core.valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(LAT));
        chk({tag, "_rdata"}, to_core.read_data, exp_rd);
        chk({tag, "_err"}, 32'(error_o), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(to_core.valid), 32'd1);
            chk({tag, "_hold_rdata"}, to_core.read_data, exp_rd);
        end
        core_in.yumi = 1'b1;
        tick();
        core_in.yumi = 1'b0;
        chk({tag, "_valid_drop"}, 32'(to_core.valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", n_chk);
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        core_in = '0;
        addr_in = '0;
        core_in.valid = 1'b1;
        #3;
        chk("rst_valid", 32'(to_core.valid), 32'd0);
        chk("rst_yumi", 32'(to_core.yumi), 32'd0);
        chk("rst_rdata", to_core.read_data, 32'd0);
        chk("rst_err", 32'(error_o), 32'd0);
        core_in.valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        do_req("wr10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        do_req("rd10", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        do_req("wrb13", 1'b1, 1'b1, 32'h13, 32'h123456A5, 32'h0, 1'b0, 0);
        do_req("rd10b", 1'b0, 1'b0, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 0);
        do_req("rdb13", 1'b0, 1'b1, 32'h13, 32'h0, 32'h000000A5, 1'b0, 0);
        do_req("rdb11", 1'b0, 1'b1, 32'h11, 32'h0, 32'h000000BE, 1'b0, 0);
        do_req("rdhold", 1'b0, 1'b0, 32'h12, 32'h0, 32'hA5ADBEEF, 1'b0, 5);

        // valid and yumi held high across a full transaction
        core_in.valid      = 1'b1;
        core_in.wen        = 1'b1;
        core_in.byte_not_word = 1'b0;
        core_in.write_data = 32'h11111111;
        core_in.yumi       = 1'b1;
        addr_in            = 32'h20;
        #1;
        chk("held_yumi_t0", 32'(to_core.yumi), 32'd1);
        tick();
        chk("held_yumi_t1", 32'(to_core.yumi), 32'd0);
        chk("held_valid_t1", 32'(to_core.valid), 32'd0);
        tick();
        chk("held_valid_t2", 32'(to_core.valid), 32'd1);
        chk("held_yumi_t2", 32'(to_core.yumi), 32'd0);
        tick();
        chk("held_valid_t3", 32'(to_core.valid), 32'd0);
        chk("held_yumi_t3", 32'(to_core.yumi), 32'd1);
        tick();
        core_in.valid = 1'b0;
        chk("held_yumi_t4", 32'(to_core.yumi), 32'd0);
        tick();
        chk("held_valid_t5", 32'(to_core.valid), 32'd1);
        tick();
        chk("held_valid_t6", 32'(to_core.valid), 32'd0);
        core_in.yumi = 1'b0;
        do_req("rd20", 1'b0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 0);

        // reset while a write to 0x20 sits in BUSY
        core_in.valid      = 1'b1;
        core_in.wen        = 1'b1;
        core_in.write_data = 32'h22222222;
        addr_in            = 32'h20;
        tick();
        core_in.valid = 1'b0;
        reset = 1'b0;
        #1;
        core_in.valid = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(to_core.valid), 32'd0);
        chk("mid_rst_rdata", to_core.read_data, 32'd0);
        chk("mid_rst_yumi", 32'(to_core.yumi), 32'd0);
        chk("mid_rst_err", 32'(error_o), 32'd0);
        core_in.valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        do_req("rd20_post", 1'b0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 0);

`ifdef DMEM_RANGE_CHECK_EN
        do_req("wr_oor", 1'b1, 1'b0, 32'h00001010, 32'hCAFEF00D, 32'h0, 1'b1, 0);
        chk("oor_err_clear", 32'(error_o), 32'd0);
        do_req("rd_oor", 1'b0, 1'b0, 32'h00001010, 32'h0, 32'h0, 1'b1, 0);
        do_req("rd10_oor", 1'b0, 1'b0, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 0);
`else
        do_req("wr_wrap", 1'b1, 1'b0, 32'h00001010, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        do_req("rd10_wrap", 1'b0, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 0);
        do_req("rd_hi_wrap", 1'b0, 1'b0, 32'hFFFFF010, 32'h0, 32'hCAFEF00D, 1'b0, 0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
